// File: rtl/axistream_snooper_pkg.sv
// Shared definitions for the snooper and the forwarder: capture FSM states
// and the rule relating packet-length width to packet-memory address width.
package axistream_snooper_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } snoop_state_e;

   // A full buffer holds 2^addr_width flits, so its length needs one more bit.
   function automatic int plen_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/axistream_snooper_if.sv
// AXI Stream bus between an upstream source (master) and the snooper (slave).
interface axistream_snooper_if #(
   parameter int DATA_WIDTH = 64
) ();

   logic [DATA_WIDTH-1:0] TDATA;
   logic                  TVALID;
   logic                  TLAST;
   logic                  TREADY;

   modport master (output TDATA, output TVALID, output TLAST, input TREADY);
   modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);

endinterface

// File: rtl/axistream_snooper.sv
// Captures one AXI Stream packet at a time into a packet-memory buffer,
// truncating packets longer than the buffer and reporting length on completion.
module axistream_snooper
   import axistream_snooper_pkg::*;
#(
   parameter  int DATA_WIDTH = 64,
   parameter  int ADDR_WIDTH = 9,
   localparam int PLEN_WIDTH = plen_width(ADDR_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   axistream_snooper_if.slave    axis,
   input  logic                  ready_for_snooper,
   output logic [ADDR_WIDTH-1:0] snooper_wr_addr,
   output logic [DATA_WIDTH-1:0] snooper_wr_data,
   output logic                  snooper_wr_en,
   output logic                  snooper_done,
   output logic [PLEN_WIDTH-1:0] snooper_len,
   output logic                  snooper_trunc
);

   localparam logic [PLEN_WIDTH-1:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   snoop_state_e          state_q, state_d;
   logic [PLEN_WIDTH-1:0] count_q;
   logic                  trunc_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic                  wr_en_q;

   logic                  tready_c;
   logic                  accept_c;
   logic                  store_c;
   logic                  done_c;
   logic [PLEN_WIDTH-1:0] len_c;
   logic                  trunc_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               state_d = axis.TLAST ? ST_FLUSH : ST_RECV;
            end
         end
         ST_RECV: begin
            if (accept_c) begin
               if (axis.TLAST) begin
                  state_d = ST_FLUSH;
               end else if (count_q + PLEN_WIDTH'(1) == FULL_COUNT) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (accept_c && axis.TLAST) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tready_c = 1'b0;
      done_c   = 1'b0;
      len_c    = '0;
      trunc_c  = 1'b0;
      case (state_q)
         ST_IDLE:  tready_c = ready_for_snooper;
         ST_RECV:  tready_c = 1'b1;
         ST_DRAIN: tready_c = 1'b1;
         ST_DONE: begin
            done_c  = 1'b1;
            len_c   = count_q;
            trunc_c = trunc_q;
         end
         default: tready_c = 1'b0;
      endcase
      accept_c = axis.TVALID && tready_c;
      // Flits arriving once the buffer is full are accepted but never stored.
      store_c  = accept_c && ((state_q == ST_IDLE) || (state_q == ST_RECV));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         trunc_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
      end else begin
         wr_en_q <= store_c;
         if (store_c) begin
            wr_addr_q <= count_q[ADDR_WIDTH-1:0];
            wr_data_q <= axis.TDATA;
            count_q   <= count_q + PLEN_WIDTH'(1);
         end
         if ((state_q == ST_DRAIN) && accept_c && axis.TLAST) begin
            trunc_q <= 1'b1;
         end
         if (state_q == ST_DONE) begin
            count_q   <= '0;
            trunc_q   <= 1'b0;
            wr_addr_q <= '0;
         end
      end
   end

   // Gated so the bus sees no ready while reset is held, regardless of the buffer.
   assign axis.TREADY     = rst_n & tready_c;
   assign snooper_wr_addr = wr_addr_q;
   assign snooper_wr_data = wr_data_q;
   assign snooper_wr_en   = wr_en_q;
   assign snooper_done    = done_c;
   assign snooper_len     = len_c;
   assign snooper_trunc   = trunc_c;

endmodule
